// File: rtl/seg7_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the 8-digit seven-segment display controller.
// Latency: n/a (package: FSM state enum, glyph constants, glyph lookup helper).
// Backpressure: n/a.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int BIN_W      = 32;
    localparam int BCD_DIGITS = 10;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_A     = 7'b0001000;
    localparam logic [6:0] GLYPH_B     = 7'b0000011;
    localparam logic [6:0] GLYPH_C     = 7'b1000110;
    localparam logic [6:0] GLYPH_D     = 7'b0100001;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_F     = 7'b0001110;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    function automatic logic [6:0] glyph_of(input logic [3:0] dig);
        logic [6:0] g;
        case (dig)
            4'h0:    g = GLYPH_0;
            4'h1:    g = GLYPH_1;
            4'h2:    g = GLYPH_2;
            4'h3:    g = GLYPH_3;
            4'h4:    g = GLYPH_4;
            4'h5:    g = GLYPH_5;
            4'h6:    g = GLYPH_6;
            4'h7:    g = GLYPH_7;
            4'h8:    g = GLYPH_8;
            4'h9:    g = GLYPH_9;
            4'hA:    g = GLYPH_A;
            4'hB:    g = GLYPH_B;
            4'hC:    g = GLYPH_C;
            4'hD:    g = GLYPH_D;
            4'hE:    g = GLYPH_E;
            default: g = GLYPH_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
`timescale 1ns/1ps
// Sequential double-dabble: 32-bit binary to 10-digit BCD, one bit per cycle.
// Latency: start_i edge loads, then 32 shift cycles; done_o high in the 32nd, bcd_o valid after it.
// Backpressure: none; a new start_i restarts the conversion unconditionally.
// Ports: io_clk/resetn clock and async active-low reset; start_i load pulse; bin_i operand;
//        done_o final-step strobe; bcd_o packed BCD result (digit i at [4i+3:4i]).
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic             io_clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic             done_o,
    output logic [BCD_W-1:0] bcd_o
);

    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d, bcd_adj;
    logic [4:0]       cnt_q;
    logic             run_q;

    // Add-3 correction on every digit >= 5, then shift {bcd, bin} left by one.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
    end

    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            bin_q <= bin_i;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                run_q <= 1'b0;
            end
        end
    end

    // Combinational so the caller can leave its shift state on the same edge
    // that commits the final step.
    assign done_o = run_q && (cnt_q == 5'd31);
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg7_display_ctrl.sv
`timescale 1ns/1ps
// 8-digit multiplexed seven-segment controller with hex or decimal (double-dabble) display.
// Latency: disp updates 2 edges (hex) / 34 edges (decimal) after the edge sampling a changed input.
// Backpressure: inputs changing while a conversion is in flight are picked up in the next IDLE cycle.
// Ports: io_clk/resetn clock and async active-low reset; value/mode/blank_lz display controls;
//        seg_n active-low segments (bit0=a); an_n active-low digit enables (bit0=rightmost);
//        busy high while decimal conversion shifts.
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        io_clk,
    input  logic        resetn,
    input  logic [31:0] value,
    input  logic        mode,
    input  logic        blank_lz,
    output logic [6:0]  seg_n,
    output logic [7:0]  an_n,
    output logic        busy
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t           state_q, state_d;
    logic [31:0]      snap_value_q;
    logic             snap_mode_q;
    logic [31:0]      disp_q, disp_d;
    logic             ovf_q, ovf_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [2:0]       idx_q, idx_d;
    logic [6:0]       seg_n_q, seg_n_d;
    logic [7:0]       an_n_q, an_n_d;

    logic             in_diff;
    logic             capture;
    logic             bcd_start;
    logic             bcd_done;
    logic [BCD_W-1:0] bcd;
    logic             load_disp;

    assign in_diff   = (value != snap_value_q) || (mode != snap_mode_q);
    assign capture   = (state_q == ST_IDLE) && in_diff;
    // The converter loads the live input on the capture edge, the same value
    // that lands in the snapshot.
    assign bcd_start = capture && mode;

    bin2bcd_seq u_bin2bcd (
        .io_clk  (io_clk),
        .resetn  (resetn),
        .start_i (bcd_start),
        .bin_i   (value),
        .done_o  (bcd_done),
        .bcd_o   (bcd)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_diff) state_d = mode ? ST_SHIFT : ST_DONE;
            ST_SHIFT: if (bcd_done) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy      = (state_q == ST_SHIFT);
        load_disp = (state_q == ST_DONE);
    end

    // Display register and overflow: written only in DONE, so a partial BCD
    // result is never visible on the digits.
    always_comb begin
        disp_d = disp_q;
        ovf_d  = ovf_q;
        if (load_disp) begin
            disp_d = snap_mode_q ? bcd[31:0] : snap_value_q;
            ovf_d  = snap_mode_q && (bcd[BCD_W-1:32] != '0);
        end
    end

    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            snap_value_q <= '0;
            snap_mode_q  <= 1'b0;
            disp_q       <= '0;
            ovf_q        <= 1'b0;
        end else begin
            if (capture) begin
                snap_value_q <= value;
                snap_mode_q  <= mode;
            end
            disp_q <= disp_d;
            ovf_q  <= ovf_d;
        end
    end

    // ---------------- Scan prescaler and digit index ----------------
    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = idx_q + 3'd1;
        end
    end

    // ---------------- Glyph selection ----------------
    logic [3:0] cur_dig;
    logic       upper_zero;

    assign cur_dig = disp_q[{idx_q, 2'b00} +: 4];

    // True when the current digit and every digit above it are zero.
    always_comb begin
        upper_zero = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if ((j >= int'(idx_q)) && (disp_q[4*j +: 4] != 4'd0)) begin
                upper_zero = 1'b0;
            end
        end
    end

    always_comb begin
        an_n_d = ~(8'd1 << idx_q);
        if (ovf_q) begin
            seg_n_d = GLYPH_DASH;
        end else if (blank_lz && (idx_q != 3'd0) && upper_zero) begin
            seg_n_d = GLYPH_BLANK;
        end else begin
            seg_n_d = glyph_of(cur_dig);
        end
    end

    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            presc_q <= '0;
            idx_q   <= '0;
            an_n_q  <= 8'b11111110;
            seg_n_q <= GLYPH_0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_n_q  <= an_n_d;
            seg_n_q <= seg_n_d;
        end
    end

    assign seg_n = seg_n_q;
    assign an_n  = an_n_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
`timescale 1ns/1ps
// Directed bench for seg7_display_ctrl with SCAN_DIV = 4.
// Latency: edge-accurate checks of conversion timing, scan sequencing and reset.
// Backpressure: n/a.
module tb_seg7_display_ctrl;

    logic        io_clk   = 1'b0;
    logic        resetn   = 1'b0;
    logic [31:0] value    = 32'd0;
    logic        mode     = 1'b0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg_n;
    logic [7:0]  an_n;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 io_clk = ~io_clk;

    seg7_display_ctrl #(.SCAN_DIV(4)) dut (
        .io_clk   (io_clk),
        .resetn   (resetn),
        .value    (value),
        .mode     (mode),
        .blank_lz (blank_lz),
        .seg_n    (seg_n),
        .an_n     (an_n),
        .busy     (busy)
    );

    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    function automatic logic [6:0] g(input int d);
        logic [6:0] r;
        case (d)
            0:  r = 7'b1000000;
            1:  r = 7'b1111001;
            2:  r = 7'b0100100;
            3:  r = 7'b0110000;
            4:  r = 7'b0011001;
            5:  r = 7'b0010010;
            6:  r = 7'b0000010;
            7:  r = 7'b1111000;
            8:  r = 7'b0000000;
            9:  r = 7'b0010000;
            10: r = 7'b0001000;
            11: r = 7'b0000011;
            12: r = 7'b1000110;
            13: r = 7'b0100001;
            14: r = 7'b0000110;
            default: r = 7'b0001110;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge io_clk);
            #1;
        end
    endtask

    // Walk digits 0..7 in scan order, checking the glyph shown with each enable.
    task automatic check_scan(input string tag, input logic [7:0][6:0] exp);
        for (int d = 0; d < 8; d++) begin
            logic [7:0] want_an;
            bit ok;
            want_an = ~(8'd1 << d);
            ok = 1'b0;
            for (int t = 0; t < 64 && !ok; t++) begin
                if (an_n == want_an) ok = 1'b1;
                else tick();
            end
            if (!ok) chk($sformatf("%s_an%0d_timeout", tag, d), 32'(an_n), 32'(want_an));
            else     chk($sformatf("%s_dig%0d", tag, d), 32'(seg_n), 32'(exp[d]));
        end
    endtask

    // Decimal conversion: capture edge, wait out SHIFT, then the DONE edge.
    task automatic conv();
        int t;
        tick();
        t = 0;
        while (busy && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) chk("conv_timeout", 32'(busy), 32'd0);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        logic [7:0] prev_an;

        // ---- Reset state ----
        tick();
        chk("rst_an", 32'(an_n), 32'h000000FE);
        chk("rst_seg", 32'(seg_n), 32'(7'b1000000));
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_disp", dut.disp_q, 32'd0);
        chk("rst_ovf", 32'(dut.ovf_q), 32'd0);
        resetn = 1'b1;
        tick(5);
        chk("noconv_busy", 32'(busy), 32'd0);
        chk("noconv_disp", dut.disp_q, 32'd0);
        check_scan("rst_scan", {8{g(0)}});

        // ---- Scenario 1: hex 1234ABCD, 2-edge latency, 4-cycle dwell ----
        value = 32'h1234ABCD;
        mode  = 1'b0;
        tick();
        chk("hex_lat_e0", dut.disp_q, 32'd0);
        chk("hex_busy", 32'(busy), 32'd0);
        tick();
        chk("hex_lat_e1", dut.disp_q, 32'h1234ABCD);
        chk("hex_ovf", 32'(dut.ovf_q), 32'd0);
        check_scan("hex", {g(1), g(2), g(3), g(4), g(10), g(11), g(12), g(13)});
        prev_an = an_n;
        cnt = 0;
        while (an_n == prev_an && cnt < 20) begin tick(); cnt++; end
        prev_an = an_n;
        cnt = 0;
        while (an_n == prev_an && cnt < 20) begin tick(); cnt++; end
        chk("dwell", cnt, 32'd4);

        // ---- Scenario 2: decimal 12345678, busy 32 cycles, 34-edge latency ----
        value = 32'd12345678;
        mode  = 1'b1;
        tick();
        chk("dec_busy_start", 32'(busy), 32'd1);
        cnt = 0;
        while (busy && cnt < 100) begin cnt++; tick(); end
        chk("dec_busy_len", cnt, 32'd32);
        chk("dec_lat_e32", dut.disp_q, 32'h1234ABCD);
        tick();
        chk("dec_lat_e33", dut.disp_q, 32'h12345678);
        chk("dec_ovf", 32'(dut.ovf_q), 32'd0);
        check_scan("dec", {g(1), g(2), g(3), g(4), g(5), g(6), g(7), g(8)});

        // ---- Scenario 3: overflow at 100000000 ----
        value = 32'd100000000;
        conv();
        chk("ovf_flag", 32'(dut.ovf_q), 32'd1);
        check_scan("ovf", {8{DASH}});
        blank_lz = 1'b1;
        check_scan("ovf_blk", {8{DASH}});

        // ---- Scenario 4: leading-zero blanking, applied live ----
        value = 32'd42;
        conv();
        chk("d42_disp", dut.disp_q, 32'h00000042);
        check_scan("blk42", {{6{BLANK}}, g(4), g(2)});
        blank_lz = 1'b0;
        check_scan("noblk42", {{6{g(0)}}, g(4), g(2)});
        chk("live_nobusy", 32'(busy), 32'd0);
        blank_lz = 1'b1;
        value = 32'd0;
        conv();
        check_scan("blk0", {{7{BLANK}}, g(0)});
        blank_lz = 1'b0;

        // ---- Scenario 5: input change mid-SHIFT ----
        value = 32'd5;
        tick();
        chk("s5_busy", 32'(busy), 32'd1);
        tick(10);
        value = 32'd9;
        tick(22);
        chk("s5_e32", dut.disp_q, 32'd0);
        tick();
        chk("s5_e33", dut.disp_q, 32'd5);
        tick();
        chk("s5_recap_busy", 32'(busy), 32'd1);
        tick(32);
        chk("s5_e66", dut.disp_q, 32'd5);
        tick();
        chk("s5_e67", dut.disp_q, 32'd9);

        // ---- Scenario 6: asynchronous reset mid-SHIFT ----
        value = 32'd77;
        tick(6);
        chk("s6_pre_busy", 32'(busy), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("s6_async_an", 32'(an_n), 32'h000000FE);
        chk("s6_async_seg", 32'(seg_n), 32'(7'b1000000));
        chk("s6_async_busy", 32'(busy), 32'd0);
        chk("s6_async_disp", dut.disp_q, 32'd0);
        tick();
        resetn = 1'b1;
        tick(4);
        chk("s6_idx_hold", 32'(an_n), 32'h000000FE);
        tick();
        chk("s6_idx_step", 32'(an_n), 32'h000000FD);
        tick(28);
        chk("s6_disp_zero", dut.disp_q, 32'd0);
        tick();
        chk("s6_disp_new", dut.disp_q, 32'h00000077);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
